// File: rtl/mips_fetch_stage.sv
// Instruction fetch stage: word-aligned imem reads buffered in a prefetch FIFO feeding IF/ID.
// Optional fetch-time J-type folding is enabled by defining MIPS_FETCH_EARLY_JUMP_EN.
module mips_fetch_stage #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH      = 4,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        if_id_valid_o,
  output logic [31:0] if_id_instr_o,
  output logic [31:0] if_id_pc4_o,
  output logic        if_id_pred_o,
  input  logic        id_ready_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i
);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned QW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned OW = CW + 1;
  localparam logic [QW-1:0] Q_LAST = QW'(MAX_OUTSTANDING - 1);

  logic [31:0]   fetch_pc;
  logic [31:0]   fifo_instr [FIFO_DEPTH];
  logic [31:0]   fifo_pc4   [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] fifo_count, outstanding, drop;
  logic [31:0]   pc4_q [MAX_OUTSTANDING];
  logic [QW-1:0] q_rd, q_wr;

  logic          fire, push, pop;
  logic [31:0]   resp_pc4;
  logic [CW-1:0] outstanding_nxt;
  logic [OW-1:0] occupancy;

  // Request only when every granted word is guaranteed a FIFO slot and no stale data is pending.
  assign occupancy  = OW'(fifo_count) + OW'(outstanding);
  assign imem_req_o = !rst && !redirect_i && (occupancy < OW'(FIFO_DEPTH))
                      && (outstanding < CW'(MAX_OUTSTANDING)) && (drop == '0);
  assign imem_addr_o = fetch_pc;

  assign fire     = imem_req_o && imem_gnt_i;
  assign push     = imem_rvalid_i && (drop == '0) && !redirect_i;
  assign pop      = if_id_valid_o && id_ready_i && !redirect_i;
  assign resp_pc4 = pc4_q[q_rd];
  assign outstanding_nxt = outstanding + CW'(fire) - CW'(imem_rvalid_i);

  assign if_id_valid_o = (fifo_count != '0);
  assign if_id_instr_o = fifo_instr[rd_ptr];
  assign if_id_pc4_o   = fifo_pc4[rd_ptr];

`ifdef MIPS_FETCH_EARLY_JUMP_EN
  logic [FIFO_DEPTH-1:0] fifo_pred;
  logic                  take_jump;
  logic [31:0]           jump_target;

  assign take_jump    = push && (imem_rdata_i[31:26] == 6'b000010);
  assign jump_target  = {resp_pc4[31:28], imem_rdata_i[25:0], 2'b00};
  assign if_id_pred_o = fifo_pred[rd_ptr];
`else
  assign if_id_pred_o = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      fifo_count  <= '0;
      outstanding <= '0;
      drop        <= '0;
      q_rd        <= '0;
      q_wr        <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        fifo_instr[i] <= '0;
        fifo_pc4[i]   <= '0;
      end
      for (int i = 0; i < int'(MAX_OUTSTANDING); i++) begin
        pc4_q[i] <= '0;
      end
`ifdef MIPS_FETCH_EARLY_JUMP_EN
      fifo_pred <= '0;
`endif
    end else begin
      outstanding <= outstanding_nxt;
      if (fire) begin
        fetch_pc    <= fetch_pc + 32'd4;
        pc4_q[q_wr] <= fetch_pc + 32'd4;
        q_wr        <= (q_wr == Q_LAST) ? '0 : q_wr + QW'(1);
      end
      if (imem_rvalid_i) begin
        q_rd <= (q_rd == Q_LAST) ? '0 : q_rd + QW'(1);
      end

      // Redirect flushes the buffer; everything still in flight becomes stale.
      if (redirect_i) begin
        fetch_pc   <= redirect_pc_i;
        drop       <= outstanding_nxt;
        rd_ptr     <= '0;
        wr_ptr     <= '0;
        fifo_count <= '0;
      end else begin
        if (imem_rvalid_i && (drop != '0)) begin
          drop <= drop - CW'(1);
        end
        if (push) begin
          fifo_instr[wr_ptr] <= imem_rdata_i;
          fifo_pc4[wr_ptr]   <= resp_pc4;
`ifdef MIPS_FETCH_EARLY_JUMP_EN
          fifo_pred[wr_ptr]  <= take_jump;
`endif
          wr_ptr <= wr_ptr + PW'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PW'(1);
        end
        fifo_count <= fifo_count + CW'(push) - CW'(pop);
`ifdef MIPS_FETCH_EARLY_JUMP_EN
        // Jump folded at fetch: younger requests, including one granted now, are stale.
        if (take_jump) begin
          fetch_pc <= jump_target;
          drop     <= outstanding_nxt;
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_mips_fetch_stage.sv
// Bench for mips_fetch_stage: directed scenarios plus randomized memory timing, stalls and
// redirects, checked every cycle against an epoch-based model of the expected instruction stream.
module tb_mips_fetch_stage;
  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam int          FIFO_DEPTH = 4;
  localparam int          MAX_OUT    = 2;
`ifdef MIPS_FETCH_EARLY_JUMP_EN
  localparam bit EJ = 1'b1;
`else
  localparam bit EJ = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        if_id_valid_o;
  logic [31:0] if_id_instr_o;
  logic [31:0] if_id_pc4_o;
  logic        if_id_pred_o;
  logic        id_ready_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;

  mips_fetch_stage #(
    .RESET_PC(RESET_PC), .FIFO_DEPTH(FIFO_DEPTH), .MAX_OUTSTANDING(MAX_OUT)
  ) dut (
    .clk(clk), .rst(rst),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .if_id_valid_o(if_id_valid_o), .if_id_instr_o(if_id_instr_o),
    .if_id_pc4_o(if_id_pc4_o), .if_id_pred_o(if_id_pred_o),
    .id_ready_i(id_ready_i), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc4; logic [31:0] instr; logic pred; } ent_t;
  typedef struct { logic [31:0] addr; int epoch; int due; } req_t;
  typedef struct { logic [31:0] pc4; logic pred; } pop_t;

  ent_t        mq[$];
  req_t        pend[$];
  logic [31:0] grant_log[$];
  pop_t        pop_log[$];

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          epoch = 0;
  logic [31:0] exp_req_addr = RESET_PC;
  bit          rst_d = 1'b0;

  bit          gnt_rand = 1'b0, ready_rand = 1'b0, redir_rand = 1'b0;
  bit          ready_hold = 1'b1, force_redir = 1'b0, coincide = 1'b0;
  logic [31:0] force_pc = 32'h0;
  int          dmin = 1, dmax = 1;

  // Instruction memory image: a jump to 0 at 0x18, a jump to 0x100 at 0x3F0, loads elsewhere.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0018) return 32'h0800_0000;
    if (a == 32'h0000_03F0) return 32'h0800_0040;
    return {6'h23, 26'(a ^ 32'h0155_AA55)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: each grant is tagged with the current epoch; a redirect or a folded jump opens a
  // new epoch, and only responses from the current epoch reach the delivered stream.
  always @(negedge clk) begin
    req_t        r;
    pop_t        p;
    ent_t        e;
    logic [31:0] w;
    chk("req_in_reset", imem_req_o & rst, 0);
    if (rst) begin
      if (rst_d) begin
        chk("rst_addr", imem_addr_o, RESET_PC);
        chk("rst_valid", if_id_valid_o, 0);
        chk("rst_instr", if_id_instr_o, 0);
        chk("rst_pc4", if_id_pc4_o, 0);
        chk("rst_pred", if_id_pred_o, 0);
      end
      mq.delete();
      pend.delete();
      epoch = 0;
      exp_req_addr = RESET_PC;
    end else begin
      chk("valid", if_id_valid_o, mq.size() != 0);
      if (mq.size() != 0) begin
        chk("instr", if_id_instr_o, mq[0].instr);
        chk("pc4", if_id_pc4_o, mq[0].pc4);
        chk("pred", if_id_pred_o, mq[0].pred);
      end
      if (redirect_i) chk("req_in_redirect", imem_req_o, 0);
      if (redirect_i && imem_rvalid_i && if_id_valid_o && id_ready_i) coincide = 1'b1;
      if (imem_req_o && imem_gnt_i) begin
        chk("req_addr", imem_addr_o, exp_req_addr);
        chk("outstanding_limit", pend.size() < MAX_OUT, 1);
        r.addr  = imem_addr_o;
        r.epoch = epoch;
        r.due   = cyc + int'($urandom_range(dmin, dmax));
        pend.push_back(r);
        grant_log.push_back(imem_addr_o);
        exp_req_addr = exp_req_addr + 32'd4;
      end
      if (if_id_valid_o && id_ready_i && !redirect_i && mq.size() != 0) begin
        p.pc4  = if_id_pc4_o;
        p.pred = if_id_pred_o;
        pop_log.push_back(p);
        void'(mq.pop_front());
      end
      if (imem_rvalid_i && pend.size() != 0) begin
        r = pend.pop_front();
        if (!redirect_i && r.epoch == epoch) begin
          w       = mem_word(r.addr);
          e.pc4   = r.addr + 32'd4;
          e.instr = w;
          e.pred  = EJ && (w[31:26] == 6'b000010);
          mq.push_back(e);
          if (e.pred) begin
            exp_req_addr = {e.pc4[31:28], w[25:0], 2'b00};
            epoch++;
          end
        end
      end
      if (redirect_i) begin
        mq.delete();
        exp_req_addr = redirect_pc_i;
        epoch++;
      end
    end
    rst_d = rst;
    cyc++;
  end

  // Memory responder and downstream driver; inputs change 1 time unit after the rising edge.
  always @(posedge clk) begin
    #1;
    imem_gnt_i = gnt_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    if (!rst && pend.size() != 0 && pend[0].due <= cyc) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = mem_word(pend[0].addr);
    end else begin
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = $urandom;
    end
    id_ready_i = ready_rand ? ($urandom_range(0, 3) != 0) : ready_hold;
    if (force_redir) begin
      redirect_i    = 1'b1;
      redirect_pc_i = force_pc;
      force_redir   = 1'b0;
    end else if (redir_rand && $urandom_range(0, 39) == 0) begin
      redirect_i    = 1'b1;
      redirect_pc_i = ($urandom_range(0, 7) == 0)
                      ? {28'hFFF_FFFF, 2'($urandom_range(0, 3)), 2'b00}
                      : {22'd0, 8'($urandom_range(0, 255)), 2'b00};
    end else begin
      redirect_i    = 1'b0;
      redirect_pc_i = $urandom & 32'hFFFF_FFFC;
    end
  end

  initial begin
    logic [31:0] h;
    bit          found;
    rst = 1'b1; imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = '0;
    id_ready_i = 1'b1; redirect_i = 1'b0; redirect_pc_i = '0;
    repeat (4) @(posedge clk);

    // Reset release, zero-wait memory, full-rate sequential fetch.
    @(posedge clk); grant_log.delete(); pop_log.delete(); #1 rst = 1'b0;
    @(negedge clk); chk("t1_first_req", imem_req_o, 1); chk("t1_first_addr", imem_addr_o, 32'h0);
    @(negedge clk); chk("t1_valid_n1", if_id_valid_o, 0);
    @(negedge clk); chk("t1_valid_n2", if_id_valid_o, 1); chk("t1_pc4_n2", if_id_pc4_o, 32'h4);
    repeat (8) @(negedge clk);
    chk("t1_grant_count", grant_log.size() >= 10, 1);
    for (int i = 0; i < 10 && i < int'(grant_log.size()); i++)
      chk("t1_seq_addr", grant_log[i], 32'(4 * i));

    // Decode stall: buffer fills, requests stop, head holds, then drains in order.
    @(posedge clk); ready_hold = 1'b0;
    @(negedge clk); h = if_id_pc4_o;
    repeat (9) @(negedge clk);
    chk("t3_req_stopped", imem_req_o, 0);
    chk("t3_head_pc4_stable", if_id_pc4_o, h);
    chk("t3_head_instr", if_id_instr_o, mem_word(h - 32'd4));
    @(posedge clk);
    chk("t3_buffered", mq.size(), 32'(FIFO_DEPTH));
    pop_log.delete(); ready_hold = 1'b1;
    repeat (6) @(posedge clk);
    chk("t3_pop_count", pop_log.size() >= 4, 1);
    for (int i = 0; i < 4 && i < int'(pop_log.size()); i++)
      chk("t3_pop_seq", pop_log[i].pc4, h + 32'(4 * i));

    // Redirect to 0x40 with two slow responses outstanding.
    @(posedge clk); #1 rst = 1'b1; dmin = 3; dmax = 3;
    repeat (2) @(posedge clk); #1 rst = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(posedge clk);
      if (pend.size() == 2) found = 1'b1;
    end
    chk("t4_two_outstanding", found, 1);
    force_pc = 32'h40; force_redir = 1'b1; grant_log.delete(); pop_log.delete();
    for (int k = 0; k < 40 && pop_log.size() == 0; k++) @(posedge clk);
    chk("t4_delivered", pop_log.size() != 0, 1);
    if (grant_log.size() != 0) chk("t4_first_addr", grant_log[0], 32'h40);
    if (pop_log.size() != 0) chk("t4_first_pc4", pop_log[0].pc4, 32'h44);

    // Redirect coincident with a landing response and a pop.
    dmin = 1; dmax = 1;
    repeat (8) @(posedge clk);
    coincide = 1'b0; force_pc = 32'h80; force_redir = 1'b1; pop_log.delete();
    repeat (10) @(posedge clk);
    chk("t5_coincident", coincide, 1);
    chk("t5_pop_count", pop_log.size() >= 3, 1);
    for (int i = 0; i < 3 && i < int'(pop_log.size()); i++)
      chk("t5_pop_seq", pop_log[i].pc4, 32'h84 + 32'(4 * i));

    // Jump word at 0x18: folded only when early jump is built in.
    force_pc = 32'h10; force_redir = 1'b1; pop_log.delete();
    repeat (16) @(posedge clk);
    chk("t6_pop_count", pop_log.size() >= 4, 1);
    if (pop_log.size() >= 4) begin
      chk("t6_pc4_0", pop_log[0].pc4, 32'h14);
      chk("t6_pc4_1", pop_log[1].pc4, 32'h18);
      chk("t6_jump_pc4", pop_log[2].pc4, 32'h1C);
      chk("t6_jump_pred", pop_log[2].pred, EJ ? 32'd1 : 32'd0);
      chk("t6_after_jump", pop_log[3].pc4, EJ ? 32'h4 : 32'h20);
    end

    // Fetch PC wraps through zero.
    force_pc = 32'hFFFF_FFF8; force_redir = 1'b1; pop_log.delete();
    repeat (10) @(posedge clk);
    chk("t7_pop_count", pop_log.size() >= 3, 1);
    if (pop_log.size() >= 3) begin
      chk("t7_wrap_0", pop_log[0].pc4, 32'hFFFF_FFFC);
      chk("t7_wrap_1", pop_log[1].pc4, 32'h0);
      chk("t7_wrap_2", pop_log[2].pc4, 32'h4);
    end

    // Random grant, response latency, stalls and redirects, with a mid-run reset.
    gnt_rand = 1'b1; dmin = 1; dmax = 3; ready_rand = 1'b1; redir_rand = 1'b1;
    repeat (1500) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (1500) @(posedge clk);
    gnt_rand = 1'b0; ready_rand = 1'b0; ready_hold = 1'b1; redir_rand = 1'b0; dmax = 1;
    repeat (30) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_fetch_stage.md
# mips_fetch_stage

Instruction fetch stage for the 32-bit 5-stage MIPS core. Issues word-aligned reads to instruction memory and buffers returned instructions in a small prefetch FIFO. Presents one instruction per cycle, with its PC+4, to the IF/ID register and decode stage. Handles decode stalls and branch/jump redirects from downstream by flushing the buffer and discarding stale in-flight responses.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset
- FIFO_DEPTH, 4, prefetch entries; power of two, ≥2
- MAX_OUTSTANDING, 2, max granted-but-unreturned imem requests; 1..FIFO_DEPTH

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous reset, active-high
- imem_req_o  out  1  read request
- imem_addr_o  out  32  byte address, [1:0]=2'b00
- imem_gnt_i  in  1  request accepted this cycle
- imem_rvalid_i  in  1  read data valid; responses in order, ≥1 cycle after grant
- imem_rdata_i  in  32  instruction word
- if_id_valid_o  out  1  instruction available
- if_id_instr_o  out  32  instruction at FIFO head
- if_id_pc4_o  out  32  PC of that instruction + 4
- if_id_pred_o  out  1  early-jump taken flag (see Configuration)
- id_ready_i  in  1  decode accepts; low = stall
- redirect_i  in  1  branch/jump resolved, refetch
- redirect_pc_i  in  32  new fetch PC, word-aligned

## Operation
- State: fetch_pc, FIFO (instr, pc4, pred), outstanding counter, drop counter.
- Request rule: imem_req_o = !rst && !redirect_i && (fifo_count + outstanding < FIFO_DEPTH) && outstanding < MAX_OUTSTANDING && drop == 0.
- imem_addr_o = fetch_pc. On req && gnt: fetch_pc += 4, outstanding++.
- On rvalid with drop == 0: push {rdata, addr+4} to FIFO, outstanding--. Each response pc4 is tracked in an in-order address queue of depth MAX_OUTSTANDING.
- On rvalid with drop > 0: discard, drop--, outstanding--.
- Pop: if_id_valid_o && id_ready_i removes the head. Outputs hold stable while stalled.
- Redirect, highest priority:
  - Flush FIFO. fetch_pc <= redirect_pc_i.
  - drop <= outstanding minus any response landing this cycle. outstanding is unchanged by the flush.
  - No request is issued in the redirect cycle.
  - A same-cycle rvalid is discarded. The same-cycle pop is ignored.
- Overflow is impossible by the request rule. Push and pop in the same cycle on a full FIFO is legal.
- fetch_pc wraps modulo 2^32 (32'hFFFF_FFFC + 4 = 0).

## Timing
- Reset values: imem_req_o=0, imem_addr_o=RESET_PC, if_id_valid_o=0, if_id_instr_o=0, if_id_pc4_o=0, if_id_pred_o=0. All counters 0, FIFO empty.
- First request: the first cycle after rst deasserts.
- Latency with zero-wait memory (gnt same cycle, rvalid next cycle):
  - req in cycle N, rvalid in N+1, if_id_valid_o in N+2.
  - Steady state delivers 1 instruction/cycle when MAX_OUTSTANDING ≥ 2.
- Redirect in cycle R: first request to redirect_pc_i in R+1 if nothing is outstanding, else in the cycle after the last stale response returns. if_id_valid_o=0 from R+1 until the new data lands.
- rst mid-operation clears everything in one cycle. Instruction memory shares rst, so no stale responses follow reset.

## Configuration
- MIPS_FETCH_EARLY_JUMP_EN defined:
  - Each pushed word with opcode [31:26]=6'b000010 is enqueued with pred=1.
  - fetch_pc <= {pc4[31:28], instr[25:0], 2'b00}.
  - Younger in-flight responses are dropped exactly as on redirect.
  - Decode must not re-redirect when if_id_pred_o=1.
  - External redirect_i in the same cycle wins.
- Undefined: no opcode inspection. if_id_pred_o tied 0. Jumps are taken only via redirect_i.

## Test plan
- Reset release, zero-wait memory, id_ready_i=1 -> addresses 0,4,8,… one per cycle; first if_id_valid_o 2 cycles after first req with if_id_pc4_o=4.
- Hold id_ready_i=0 for 10 cycles -> exactly FIFO_DEPTH entries buffered; req stops; head instr/pc4 stable; 4 sequential pops on release.
- Redirect to 0x40 with 2 responses outstanding -> both discarded; next req addr 0x40 after drop reaches 0; next delivered pc4=0x44.
- Redirect coincident with rvalid and pop -> that response discarded; FIFO empty next cycle; no duplicate or lost instruction after refetch.
- Early-jump enabled, word 32'h0800_0000 at address 0x18 -> delivered with if_id_pred_o=1; next delivered pc4=0x4; words from 0x1C onward never delivered. Disabled -> if_id_pred_o=0 and 0x1C is delivered.
- imem_gnt_i random 50%, rvalid delay 1–3 cycles -> delivered pc4 sequence strictly +4 between redirects; outstanding never exceeds MAX_OUTSTANDING.
